// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: function-select codes shared by register, IR and fetch control,
// plus the fetch sequencer state encoding.
package cpu_ctrl_pkg;
    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;
    localparam logic [1:0] FS_DEC   = 2'b10;
    localparam logic [1:0] FS_INC   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_ISSUE,
        ST_ERROR
    } fetch_state_t;
endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: counts consecutive memory-wait cycles and flags the cycle that
// would reach TIMEOUT; TIMEOUT of 0 never expires.
module fetch_wdog #(
    parameter int TIMEOUT = 16,
    localparam int WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt;

    // expired is combinational so the FSM leaves on the TIMEOUT-th wait edge
    assign expired = (TIMEOUT != 0) && inc && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !expired)
            cnt <= cnt + WAIT_W'(1);
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch controller driving PC and IR
// controls, with issue handshake, redirect, halt and memory-wait timeout.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             mem_ready,
    input  logic             issue_ready,
    input  logic             redirect,
    output logic             mem_rd,
    output logic             pc_enable,
    output logic [1:0]       pc_funsel,
    output logic             ir_enable,
    output logic [1:0]       ir_funsel,
    output logic             ir_lh,
    output logic             instr_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] fetch_count
);
    fetch_state_t state, state_nx;
    logic halt_pend, handshake, wd_clr, wd_inc, wd_expired;

    assign handshake = (state == ST_ISSUE) && issue_ready;

    fetch_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // halt is only remembered while busy and is consumed by the issue handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pend   <= 1'b0;
            fetch_count <= '0;
        end else begin
            halt_pend   <= busy && (halt_pend || halt_req) && !handshake;
            fetch_count <= fetch_count + CNT_W'(handshake);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_ERROR: state_nx = start ? ST_CLR : state;
            ST_CLR:            state_nx = ST_FETCH_LO;
            ST_FETCH_LO:       state_nx = mem_ready ? ST_FETCH_HI : wd_expired ? ST_ERROR : state;
            ST_FETCH_HI:       state_nx = mem_ready ? ST_ISSUE : wd_expired ? ST_ERROR : state;
            ST_ISSUE:          state_nx = !issue_ready ? state : (halt_pend || halt_req) ? ST_IDLE : ST_FETCH_LO;
            default:           state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd      = 1'b0;
        pc_enable   = 1'b0;
        pc_funsel   = FS_CLEAR;
        ir_enable   = 1'b0;
        ir_funsel   = FS_CLEAR;
        ir_lh       = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        err         = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        case (state)
            ST_CLR: begin
                ir_enable = 1'b1;
                busy      = 1'b1;
                wd_clr    = 1'b1;
            end
            ST_FETCH_LO, ST_FETCH_HI: begin
                mem_rd    = 1'b1;
                busy      = 1'b1;
                ir_enable = mem_ready;
                ir_funsel = mem_ready ? FS_LOAD : FS_CLEAR;
                ir_lh     = mem_ready && (state == ST_FETCH_HI);
                pc_enable = mem_ready;
                pc_funsel = mem_ready ? FS_INC : FS_CLEAR;
                wd_clr    = mem_ready;
                wd_inc    = !mem_ready;
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                pc_enable   = issue_ready && redirect;
                pc_funsel   = (issue_ready && redirect) ? FS_LOAD : FS_CLEAR;
            end
            ST_ERROR: err = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a bench-side PC/IR/memory model
// driven by the sequencer's control outputs.
module tb_fetch_sequencer;
    localparam logic [15:0] TARGET = 16'h0040;
    // {mem_rd, pc_en, pc_fs[1:0], ir_en, ir_fs[1:0], ir_lh, valid, busy, err}
    localparam logic [10:0] O_IDLE  = 11'b0_0_00_0_00_0_0_0_0;
    localparam logic [10:0] O_CLR   = 11'b0_0_00_1_00_0_0_1_0;
    localparam logic [10:0] O_LO    = 11'b1_1_11_1_01_0_0_1_0;
    localparam logic [10:0] O_HI    = 11'b1_1_11_1_01_1_0_1_0;
    localparam logic [10:0] O_WAIT  = 11'b1_0_00_0_00_0_0_1_0;
    localparam logic [10:0] O_ISSUE = 11'b0_0_00_0_00_0_1_1_0;
    localparam logic [10:0] O_REDIR = 11'b0_1_01_0_00_0_1_1_0;
    localparam logic [10:0] O_ERR   = 11'b0_0_00_0_00_0_0_0_1;

    logic clk = 1'b0;
    logic rst_n, start, halt_req, mem_ready, issue_ready, redirect;
    logic mem_rd, pc_enable, ir_enable, ir_lh, instr_valid, busy, err;
    logic [1:0] pc_funsel, ir_funsel;
    logic [15:0] fetch_count;
    logic t_mem_rd, t_pc_enable, t_ir_enable, t_ir_lh, t_instr_valid, t_busy, t_err;
    logic [1:0] t_pc_funsel, t_ir_funsel;
    logic [15:0] t_fetch_count;
    logic [10:0] outs, t_outs, exp;
    logic [15:0] pc_m, ir_m;
    logic [7:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.CNT_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .mem_ready(mem_ready), .issue_ready(issue_ready), .redirect(redirect),
        .mem_rd(mem_rd), .pc_enable(pc_enable), .pc_funsel(pc_funsel),
        .ir_enable(ir_enable), .ir_funsel(ir_funsel), .ir_lh(ir_lh),
        .instr_valid(instr_valid), .busy(busy), .err(err), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.CNT_W(16), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .mem_ready(mem_ready), .issue_ready(issue_ready), .redirect(redirect),
        .mem_rd(t_mem_rd), .pc_enable(t_pc_enable), .pc_funsel(t_pc_funsel),
        .ir_enable(t_ir_enable), .ir_funsel(t_ir_funsel), .ir_lh(t_ir_lh),
        .instr_valid(t_instr_valid), .busy(t_busy), .err(t_err), .fetch_count(t_fetch_count)
    );

    assign outs   = {mem_rd, pc_enable, pc_funsel, ir_enable, ir_funsel, ir_lh, instr_valid, busy, err};
    assign t_outs = {t_mem_rd, t_pc_enable, t_pc_funsel, t_ir_enable, t_ir_funsel, t_ir_lh,
                     t_instr_valid, t_busy, t_err};

    // PC and IR registers as the datapath would implement them
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_m <= 16'h0;
            ir_m <= 16'h0;
        end else begin
            if (pc_enable)
                case (pc_funsel)
                    2'b00: pc_m <= 16'h0;
                    2'b01: pc_m <= TARGET;
                    2'b10: pc_m <= pc_m - 16'h1;
                    default: pc_m <= pc_m + 16'h1;
                endcase
            if (ir_enable)
                case (ir_funsel)
                    2'b00: ir_m <= 16'h0;
                    2'b01: if (ir_lh) ir_m[15:8] <= mem[pc_m[7:0]];
                           else       ir_m[7:0]  <= mem[pc_m[7:0]];
                    default: ;
                endcase
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        mem_ready = 1'b0; issue_ready = 1'b0; redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        mem_ready = 1'b0; issue_ready = 1'b0; redirect = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL reset outs: got %b expected %b", outs, O_IDLE); end
        checks++;
        if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset count: got %h expected 0", fetch_count); end
        checks++;
        if (t_outs !== O_IDLE) begin errors++; $display("FAIL reset t_outs: got %b expected %b", t_outs, O_IDLE); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_ir [0:2];
        exp_ir[0] = 16'h0195; exp_ir[1] = 16'h1234; exp_ir[2] = 16'habcd;
        do_reset();
        start = 1'b1; mem_ready = 1'b1; issue_ready = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL stream idle outs: got %b expected %b", outs, O_IDLE); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            halt_req = (c == 10);
            #1;
            exp = (c == 1) ? O_CLR : (c % 3 == 2) ? O_LO : (c % 3 == 0) ? O_HI : O_ISSUE;
            checks++;
            if (outs !== exp) begin errors++; $display("FAIL stream c=%0d outs: got %b expected %b", c, outs, exp); end
            if (c > 1 && c % 3 == 1) begin
                checks++;
                if (ir_m !== exp_ir[(c-4)/3]) begin
                    errors++; $display("FAIL stream c=%0d ir: got %h expected %h", c, ir_m, exp_ir[(c-4)/3]);
                end
            end
        end
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL stream halted outs: got %b expected %b", outs, O_IDLE); end
        checks++;
        if (fetch_count !== 16'd3) begin errors++; $display("FAIL stream count: got %0d expected 3", fetch_count); end
        checks++;
        if (pc_m !== 16'd6) begin errors++; $display("FAIL stream pc: got %0d expected 6", pc_m); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        start = 1'b1; mem_ready = 1'b1; issue_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ready = !(c >= 3 && c <= 7);
            halt_req = (c == 9);
            #1;
            exp = (c == 1) ? O_CLR : (c == 2) ? O_LO : (c <= 7) ? O_WAIT : (c == 8) ? O_HI : O_ISSUE;
            checks++;
            if (outs !== exp) begin errors++; $display("FAIL wait c=%0d outs: got %b expected %b", c, outs, exp); end
        end
        checks++;
        if (ir_m !== 16'h0195) begin errors++; $display("FAIL wait ir: got %h expected 0195", ir_m); end
        @(negedge clk);
        halt_req = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL wait end outs: got %b expected %b", outs, O_IDLE); end
        checks++;
        if (pc_m !== 16'd2 || fetch_count !== 16'd1) begin
            errors++; $display("FAIL wait pc/count: got %0d/%0d expected 2/1", pc_m, fetch_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1'b1; mem_ready = 1'b0; issue_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = (c == 7);
            halt_req = (c == 6);
            #1;
            exp = (c == 1) ? O_CLR : (c <= 5) ? O_WAIT : (c <= 7) ? O_ERR : (c == 8) ? O_CLR : O_WAIT;
            checks++;
            if (t_outs !== exp) begin errors++; $display("FAIL timeout c=%0d outs: got %b expected %b", c, t_outs, exp); end
        end
        checks++;
        if (t_fetch_count !== 16'h0) begin errors++; $display("FAIL timeout count: got %0d expected 0", t_fetch_count); end
    endtask

    task automatic test_halt();
        do_reset();
        start = 1'b1; mem_ready = 1'b1; issue_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            halt_req = (c == 2);
            issue_ready = (c == 6);
            #1;
            exp = (c == 1) ? O_CLR : (c == 2) ? O_LO : (c == 3) ? O_HI : (c <= 6) ? O_ISSUE : O_IDLE;
            checks++;
            if (outs !== exp) begin errors++; $display("FAIL halt c=%0d outs: got %b expected %b", c, outs, exp); end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (ir_m !== 16'h0195) begin errors++; $display("FAIL halt c=%0d ir: got %h expected 0195", c, ir_m); end
            end
        end
        checks++;
        if (fetch_count !== 16'd1) begin errors++; $display("FAIL halt count: got %0d expected 1", fetch_count); end
        checks++;
        if (pc_m !== 16'd2) begin errors++; $display("FAIL halt pc: got %0d expected 2", pc_m); end
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1'b1; mem_ready = 1'b1; issue_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            redirect = (c == 4) || (c == 7);
            issue_ready = (c != 7);
            halt_req = (c == 8);
            #1;
            exp = (c == 1) ? O_CLR : (c == 2 || c == 5) ? O_LO : (c == 3 || c == 6) ? O_HI :
                  (c == 4) ? O_REDIR : O_ISSUE;
            checks++;
            if (outs !== exp) begin errors++; $display("FAIL redirect c=%0d outs: got %b expected %b", c, outs, exp); end
            if (c == 5) begin
                checks++;
                if (pc_m !== TARGET) begin errors++; $display("FAIL redirect pc: got %h expected %h", pc_m, TARGET); end
            end
            if (c >= 7) begin
                checks++;
                if (ir_m !== 16'h2211) begin errors++; $display("FAIL redirect c=%0d ir: got %h expected 2211", c, ir_m); end
            end
        end
        @(negedge clk);
        halt_req = 1'b0; redirect = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE || pc_m !== 16'h0042 || fetch_count !== 16'd2) begin
            errors++;
            $display("FAIL redirect end: got outs=%b pc=%h cnt=%0d expected outs=%b pc=0042 cnt=2",
                     outs, pc_m, fetch_count, O_IDLE);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1; mem_ready = 1'b1; issue_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        checks++;
        if (outs !== O_HI || fetch_count !== 16'd1) begin
            errors++; $display("FAIL arst pre: got outs=%b cnt=%0d expected outs=%b cnt=1", outs, fetch_count, O_HI);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE || fetch_count !== 16'h0) begin
            errors++; $display("FAIL arst now: got outs=%b cnt=%0d expected outs=%b cnt=0", outs, fetch_count, O_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs !== O_IDLE) begin errors++; $display("FAIL arst idle c=%0d: got %b expected %b", c, outs, O_IDLE); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5a;
        mem[0] = 8'h95; mem[1] = 8'h01; mem[2] = 8'h34;
        mem[3] = 8'h12; mem[4] = 8'hcd; mem[5] = 8'hab;
        mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
        test_reset();
        test_stream();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_redirect();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller for the register/IR datapath. It drives the PC register and the 16-bit IR through their enable/funsel/lh controls. Each instruction is fetched as two bytes over the 8-bit memory bus, low byte first, then high byte. The block presents the assembled instruction to the execute stage with a valid/ready handshake and also handles PC redirects, halt requests and a memory-wait timeout.

Parameters:
CNT_W, 16, width of retired-fetch counter fetch_count (wraps modulo 2^CNT_W)
TIMEOUT, 16, max consecutive cycles waiting on mem_ready in a fetch state before ERROR; 0 disables timeout
WAIT_W, derived = clog2(TIMEOUT+1), width of internal wait counter (localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin fetching (honoured only in IDLE or ERROR)
halt_req  in  1  request stop after current instruction is issued
mem_ready  in  1  memory byte on data bus is valid this cycle
issue_ready  in  1  execute stage accepts instruction
redirect  in  1  with issue handshake: load PC from external target instead of continuing
mem_rd  out  1  memory read strobe (address = PC)
pc_enable  out  1  PC register enable
pc_funsel  out  2  PC function select
ir_enable  out  1  IR enable
ir_funsel  out  2  IR function select
ir_lh  out  1  IR half select: 0 = low byte, 1 = high byte
instr_valid  out  1  IR holds a complete instruction for execute
busy  out  1  high in CLR, FETCH_LO, FETCH_HI, ISSUE
err  out  1  sticky memory-timeout flag
fetch_count  out  CNT_W  instructions issued since reset

Behaviour:
- Funsel encoding, shared with register/IR: 00 CLEAR, 01 LOAD, 10 DEC, 11 INC.
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including fetch_count, err, halt-pending flag and wait counter. Reset mid-fetch aborts immediately with no partial-state recovery.
- All control outputs are Moore or Mealy combinational from state plus the current-cycle inputs listed below. When not explicitly asserted they are 0 (enables 0, funsel 00, lh 0).
- IDLE: start=1 -> CLR. halt_req is ignored.
- CLR (1 cycle): ir_enable=1, ir_funsel=CLEAR; wait counter cleared -> FETCH_LO.
- FETCH_LO: mem_rd=1.
  - If mem_ready=1: ir_enable=1, ir_funsel=LOAD, ir_lh=0, pc_enable=1, pc_funsel=INC, wait counter cleared -> FETCH_HI.
  - Else: wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT -> ERROR.
- FETCH_HI: same as FETCH_LO but with ir_lh=1 -> ISSUE.
- ISSUE: instr_valid=1. IR and PC are held (enables 0) until issue_ready=1.
  - On handshake: fetch_count+1 (wraps).
  - If redirect=1: pc_enable=1, pc_funsel=LOAD.
  - Next state: IDLE if halt pending or halt_req=1 this cycle; else FETCH_LO. The halt-pending flag clears.
  - redirect without issue_ready is ignored.
- Halt: halt_req=1 in any busy state sets the pending flag. It never aborts a fetch in progress.
- ERROR: err=1, busy=0, all enables 0. start=1 -> CLR and err clears that edge. halt_req is ignored.
- start while busy is ignored.
- Throughput with mem_ready=issue_ready=1: one instruction per 3 cycles.
- First-instruction latency: start sampled at edge E0 -> CLR; E1 -> FETCH_LO; E2 -> FETCH_HI; E3 -> ISSUE, so instr_valid is high after E3.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - the FS_CLEAR/FS_LOAD/FS_DEC/FS_INC constants, used by register, IR and this block;
  - the fetch state encoding (IDLE, CLR, FETCH_LO, FETCH_HI, ISSUE, ERROR).
- One sub-module, fetch_wdog, is natural: the wait counter with clear, count enable and an expired output, parameterised by TIMEOUT.
- FSM and output decode stay in fetch_sequencer.

Test Plan:
1. Reset then start pulse with mem_ready=issue_ready=1, 3 instructions, memory bytes 0x95,0x01,... -> instr_valid high after E3. IR=0x0195 at first ISSUE. PC INC pulsed twice per instruction. fetch_count=3. Repeat period 3 cycles.
2. mem_ready low for 5 cycles in FETCH_HI, TIMEOUT=16 -> mem_rd held, no IR/PC enable during wait, then normal completion, err=0.
3. mem_ready held low, TIMEOUT=4 -> ERROR after 4 wait cycles, err=1, busy=0. start then clears err and restarts with a CLR cycle.
4. halt_req pulsed during FETCH_LO, issue_ready delayed 2 cycles -> instr_valid held 3 cycles with IR stable, fetch_count+1, then IDLE with busy=0.
5. ISSUE with redirect=1 and issue_ready=1 -> pc_funsel=01 (LOAD) with pc_enable for one cycle, no INC that cycle, next state FETCH_LO.
6. rst_n dropped asynchronously mid-FETCH_HI -> all outputs 0 immediately, fetch_count=0. After release the block stays IDLE until start.
